// File: rtl/mux9_rr_arbiter_pkg.sv
// Shared constants, output-register record and mod-9 index helper for the 9-way round-robin arbiter.
// No state, no latency, no backpressure: pure definitions.
package mux9_rr_arbiter_pkg;

  localparam int ARB_N    = 9;
  localparam int ARB_W    = 16;
  localparam int ARB_SELW = 4;

  localparam logic [ARB_SELW-1:0] SEL_IDLE  = 4'hF;
  localparam logic [ARB_SELW-1:0] PTR_RST   = 4'd8;
  localparam logic [ARB_W-1:0]    DATA_IDLE = 16'hFFFF;

  typedef struct packed {
    logic                vld;
    logic [ARB_SELW-1:0] sel;
    logic [ARB_W-1:0]    dat;
  } out_reg_t;

  // Both operands are in 0..8, so a single conditional subtract gives the mod-9 sum.
  function automatic logic [ARB_SELW-1:0] wrap9_add(input logic [ARB_SELW-1:0] a,
                                                    input logic [ARB_SELW-1:0] b);
    logic [ARB_SELW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 5'd9) sum = sum - 5'd9;
    return sum[ARB_SELW-1:0];
  endfunction

endpackage

// File: rtl/mux9_rr_arbiter_rr_pick9.sv
// Combinational round-robin pick among 9 requesters; ptr itself is lowest priority.
// Zero latency; no backpressure of its own.
module rr_pick9
  import mux9_rr_arbiter_pkg::*;
(
  input  logic [ARB_N-1:0]    req,
  input  logic [ARB_SELW-1:0] ptr,
  output logic [ARB_SELW-1:0] winner,
  output logic                any
);

  logic [ARB_SELW-1:0] base;
  logic [ARB_N-1:0]    rot;
  logic [ARB_SELW-1:0] off;

  always_comb begin
    base = (ptr >= 4'd8) ? 4'd0 : ptr + 4'd1;
    rot  = '0;
    for (int k = 0; k < ARB_N; k++) begin
      rot[k] = req[wrap9_add(base, 4'(k))];
    end
    // Descending scan so the lowest rotated position wins.
    off = '0;
    for (int k = ARB_N - 1; k >= 0; k--) begin
      if (rot[k]) off = 4'(k);
    end
    any    = |req;
    winner = any ? wrap9_add(base, off) : SEL_IDLE;
  end

endmodule

// File: rtl/mux9_rr_arbiter.sv
// Round-robin 9:1 select of 16-bit words into a valid/ready output register; req in cycle t -> out_valid in t+1.
// Holds output and withholds gnt while out_valid && !out_ready; accept-and-reload in one edge gives 1 word/cycle.
module mux9_rr_arbiter
  import mux9_rr_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ARB_N-1:0]       req,
  input  logic [ARB_N*ARB_W-1:0] data_in,
  output logic [ARB_N-1:0]       gnt,
  output logic [ARB_W-1:0]       out_data,
  output logic [ARB_SELW-1:0]    out_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  out_reg_t            out_q, out_d;
  logic [ARB_SELW-1:0] ptr_q, ptr_d;
  logic [ARB_SELW-1:0] winner;
  logic                any;
  logic                load;
  logic [ARB_W-1:0]    win_word;

  rr_pick9 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    case (winner)
      4'd0:    win_word = data_in[0*ARB_W +: ARB_W];
      4'd1:    win_word = data_in[1*ARB_W +: ARB_W];
      4'd2:    win_word = data_in[2*ARB_W +: ARB_W];
      4'd3:    win_word = data_in[3*ARB_W +: ARB_W];
      4'd4:    win_word = data_in[4*ARB_W +: ARB_W];
      4'd5:    win_word = data_in[5*ARB_W +: ARB_W];
      4'd6:    win_word = data_in[6*ARB_W +: ARB_W];
      4'd7:    win_word = data_in[7*ARB_W +: ARB_W];
      4'd8:    win_word = data_in[8*ARB_W +: ARB_W];
      default: win_word = DATA_IDLE;
    endcase
  end

  always_comb begin
    load  = any && (!out_q.vld || out_ready) && !reset;
    gnt   = '0;
    out_d = out_q;
    ptr_d = ptr_q;
    if (load) begin
      gnt[winner] = 1'b1;
      out_d       = '{vld: 1'b1, sel: winner, dat: win_word};
      ptr_d       = winner;
    end else if (out_q.vld && out_ready) begin
      // Drained with nothing waiting: return to the idle markers, keep ptr.
      out_d = '{vld: 1'b0, sel: SEL_IDLE, dat: DATA_IDLE};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '{vld: 1'b0, sel: SEL_IDLE, dat: DATA_IDLE};
      ptr_q <= PTR_RST;
    end else begin
      out_q <= out_d;
      ptr_q <= ptr_d;
    end
  end

  assign out_data  = out_q.dat;
  assign out_sel   = out_q.sel;
  assign out_valid = out_q.vld;
  assign busy      = out_q.vld;

endmodule
